// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard unit bundle between the PL_CPU pipeline and hazard_ctrl (fwd selects with HAZ_FWD_EN)
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  br_taken;
    logic                  ex_is_load;
    logic                  ex_reg_write;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  pc_sel;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pc_stall;
    logic                  if_id_stall;
`ifdef HAZ_FWD_EN
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
`endif

    // Pipeline side: reports stage contents, consumes mux selects.
    modport master (
        output br_taken, ex_is_load, ex_reg_write, ex_rd, mem_reg_write, mem_rd,
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
`ifdef HAZ_FWD_EN
        input  fwd_a_sel, fwd_b_sel,
`endif
        input  pc_sel, if_id_flush, id_ex_flush, pc_stall, if_id_stall
    );

    // Hazard unit side.
    modport slave (
        input  br_taken, ex_is_load, ex_reg_write, ex_rd, mem_reg_write, mem_rd,
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
`ifdef HAZ_FWD_EN
        output fwd_a_sel, fwd_b_sel,
`endif
        output pc_sel, if_id_flush, id_ex_flush, pc_stall, if_id_stall
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - PL_CPU hazard/control unit: boot bubbles, branch flush, RAW stall (forwarding with HAZ_FWD_EN)
module hazard_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int FLUSH_CYCLES    = 2,
    parameter int STARTUP_BUBBLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, STALL} state_t;

    state_t     state, state_nxt;
    logic [2:0] boot_cnt, boot_cnt_nxt;
    logic [1:0] flush_cnt, flush_cnt_nxt;

    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic hazard;
    logic fwd_ok;
    logic pc_sel, if_id_flush, id_ex_flush, pc_stall, if_id_stall;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic src_match(input logic use_src,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd);
        return use_src && (rs == rd) && (rd != '0);
    endfunction

    // Source/destination matches and hazard detection.
    always_comb begin
        rs1_ex  = src_match(hz.id_use_rs1, hz.id_rs1, hz.ex_rd);
        rs2_ex  = src_match(hz.id_use_rs2, hz.id_rs2, hz.ex_rd);
        rs1_mem = src_match(hz.id_use_rs1, hz.id_rs1, hz.mem_rd);
        rs2_mem = src_match(hz.id_use_rs2, hz.id_rs2, hz.mem_rd);
`ifdef HAZ_FWD_EN
        // Only a load result cannot be forwarded in time.
        hazard = hz.ex_is_load && (rs1_ex || rs2_ex);
`else
        // A load always writes its destination, so treat it as a writer too.
        hazard = ((hz.ex_reg_write || hz.ex_is_load) && (rs1_ex || rs2_ex)) ||
                 (hz.mem_reg_write && (rs1_mem || rs2_mem));
`endif
    end

    // Next-state and mux control outputs; taken branch overrides everything after boot.
    always_comb begin
        state_nxt     = state;
        boot_cnt_nxt  = boot_cnt;
        flush_cnt_nxt = flush_cnt;
        pc_sel        = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        fwd_ok        = 1'b0;
        unique case (state)
            BOOT: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                boot_cnt_nxt = boot_cnt - 3'd1;
                if (boot_cnt <= 3'd1) state_nxt = RUN;
            end
            FLUSH: begin
                if_id_flush   = 1'b1;
                flush_cnt_nxt = flush_cnt - 2'd1;
                if (flush_cnt <= 2'd1) state_nxt = RUN;
            end
            default: begin
                if (hazard) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nxt   = STALL;
                end else begin
                    fwd_ok    = 1'b1;
                    state_nxt = RUN;
                end
            end
        endcase
        if (state != BOOT && hz.br_taken) begin
            pc_sel        = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
            fwd_ok        = 1'b0;
            flush_cnt_nxt = 2'(FLUSH_CYCLES - 1);
            state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
    end

    // State register; reset drops straight back into BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            boot_cnt  <= 3'(STARTUP_BUBBLES);
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            boot_cnt  <= boot_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign hz.pc_sel      = pc_sel;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.pc_stall    = pc_stall;
    assign hz.if_id_stall = if_id_stall;

`ifdef HAZ_FWD_EN
    // Forward selects: 01 = EX result (non-load), 10 = MEM result, 00 = register file.
    always_comb begin
        hz.fwd_a_sel = 2'b00;
        hz.fwd_b_sel = 2'b00;
        if (fwd_ok) begin
            if (hz.ex_reg_write && !hz.ex_is_load && rs1_ex) hz.fwd_a_sel = 2'b01;
            else if (hz.mem_reg_write && rs1_mem)            hz.fwd_a_sel = 2'b10;
            if (hz.ex_reg_write && !hz.ex_is_load && rs2_ex) hz.fwd_b_sel = 2'b01;
            else if (hz.mem_reg_write && rs2_mem)            hz.fwd_b_sel = 2'b10;
        end
    end
`endif
endmodule
